full_adder: RTL and testbench

- Binary adder with carry-in and carry-out: sum = a + b + c.
- Built as a ripple chain of 1-bit full-adder cells, WIDTH bits wide.
- Default configuration (WIDTH=1, REG_OUT=0) is the classic combinational 1-bit full adder.
- Optional output register stage gives a 1-cycle pipelined adder for use inside clocked datapaths.

---
 rtl/full_adder_cell.sv | 13 +
 rtl/full_adder.sv | 69 ++++++
 tb/tb_full_adder.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/full_adder_cell.sv
// One-bit full-adder cell: the building block of the ripple chain.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/full_adder.sv
// WIDTH-bit ripple-carry adder built from full_adder_cell, with an optional
// single output register stage (REG_OUT=1) for use in clocked datapaths.
module full_adder #(
  parameter int WIDTH   = 1,
  parameter bit REG_OUT = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             out_valid
);

  logic [WIDTH:0]   chain;
  logic [WIDTH-1:0] sum_comb;

  assign chain[0] = c;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
      full_adder_cell u_cell (
        .a  (a[gi]),
        .b  (b[gi]),
        .ci (chain[gi]),
        .s  (sum_comb[gi]),
        .co (chain[gi+1])
      );
    end
  endgenerate

  generate
    if (REG_OUT) begin : g_reg
      logic [WIDTH-1:0] sum_reg;
      logic             carry_reg;
      logic             valid_reg;

      // Result only loads on a valid beat; out_valid tracks in_valid every edge.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sum_reg   <= '0;
          carry_reg <= 1'b0;
          valid_reg <= 1'b0;
        end else begin
          valid_reg <= in_valid;
          if (in_valid) begin
            sum_reg   <= sum_comb;
            carry_reg <= chain[WIDTH];
          end
        end
      end

      assign sum       = sum_reg;
      assign carry     = carry_reg;
      assign out_valid = valid_reg;
    end else begin : g_comb
      logic unused_clk_rst;
      assign unused_clk_rst = &{1'b0, clk, rst_n};

      assign sum       = sum_comb;
      assign carry     = chain[WIDTH];
      assign out_valid = in_valid;
    end
  endgenerate

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench: exercises combinational and registered adder variants
// with directed cases and a queue-based scoreboard for random traffic.
module tb_full_adder;

  typedef struct {
    logic        v;
    logic [15:0] s;
    logic        c;
  } exp_t;

  logic clk;
  logic rst_n;

  logic v1, a1, b1, c1, s1, co1, ov1;

  logic       v8, c8;
  logic [7:0] a8, b8, s8c, s8r;
  logic       co8c, co8r, ov8c, ov8r;

  logic        v16, c16;
  logic [15:0] a16, b16, s16c, s16r;
  logic        co16c, co16r, ov16c, ov16r;

  int tests_run;
  int tests_failed;

  exp_t q[$];

  full_adder #(.WIDTH(1), .REG_OUT(1'b0)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .a(a1), .b(b1), .c(c1),
    .sum(s1), .carry(co1), .out_valid(ov1));

  full_adder #(.WIDTH(8), .REG_OUT(1'b0)) u_d8c (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .a(a8), .b(b8), .c(c8),
    .sum(s8c), .carry(co8c), .out_valid(ov8c));

  full_adder #(.WIDTH(8), .REG_OUT(1'b1)) u_d8r (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .a(a8), .b(b8), .c(c8),
    .sum(s8r), .carry(co8r), .out_valid(ov8r));

  full_adder #(.WIDTH(16), .REG_OUT(1'b0)) u_d16c (
    .clk(clk), .rst_n(rst_n), .in_valid(v16), .a(a16), .b(b16), .c(c16),
    .sum(s16c), .carry(co16c), .out_valid(ov16c));

  full_adder #(.WIDTH(16), .REG_OUT(1'b1)) u_d16r (
    .clk(clk), .rst_n(rst_n), .in_valid(v16), .a(a16), .b(b16), .c(c16),
    .sum(s16r), .carry(co16r), .out_valid(ov16r));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [16:0] add17(input logic [15:0] x, input logic [15:0] y,
                                        input logic ci);
    return {1'b0, x} + {1'b0, y} + {16'd0, ci};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    v8 = 1'b1; a8 = 8'h12; b8 = 8'h34; c8 = 1'b1;
    v16 = 1'b1; a16 = 16'hFFFF; b16 = 16'h0001; c16 = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({s8r, co8r, ov8r} !== 10'd0) begin
      tests_failed++;
      $display("FAIL reset_w8: got sum=%h carry=%b ov=%b, want 0 0 0", s8r, co8r, ov8r);
    end
    tests_run++;
    if ({s16r, co16r, ov16r} !== 18'd0) begin
      tests_failed++;
      $display("FAIL reset_w16: got sum=%h carry=%b ov=%b, want 0 0 0", s16r, co16r, ov16r);
    end
    $display("[TB] reset: w8 sum=%h ov=%b w16 sum=%h ov=%b", s8r, ov8r, s16r, ov16r);
    v8 = 1'b0; v16 = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_truth_table();
    // {sum, carry} indexed by {a,b,c}
    logic [1:0] tt [8] = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b11};
    v1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      {a1, b1, c1} = i[2:0];
      #100;
      tests_run++;
      if ({s1, co1, ov1} !== {tt[i], 1'b1}) begin
        tests_failed++;
        $display("FAIL truth_table abc=%03b: got sum=%b carry=%b ov=%b, want sum=%b carry=%b ov=1",
                 i[2:0], s1, co1, ov1, tt[i][1], tt[i][0]);
      end
      $display("[TB] w1 abc=%03b -> sum=%b carry=%b", i[2:0], s1, co1);
    end
    v1 = 1'b0;
    #1;
    tests_run++;
    if (ov1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL comb_valid_low: got ov=%b, want 0", ov1);
    end
  endtask

  task automatic test_comb8();
    logic [7:0] av [2] = '{8'hFF, 8'h5A};
    logic [7:0] bv [2] = '{8'h00, 8'hA5};
    logic       cv [2] = '{1'b1, 1'b0};
    logic [8:0] ev [2] = '{9'h100, 9'h0FF};
    for (int i = 0; i < 2; i++) begin
      v8 = 1'b1; a8 = av[i]; b8 = bv[i]; c8 = cv[i];
      #1;
      tests_run++;
      if ({co8c, s8c} !== ev[i] || ov8c !== 1'b1) begin
        tests_failed++;
        $display("FAIL comb8_%0d: got carry=%b sum=%h ov=%b, want carry=%b sum=%h ov=1",
                 i, co8c, s8c, ov8c, ev[i][8], ev[i][7:0]);
      end
      $display("[TB] w8 comb a=%h b=%h c=%b -> sum=%h carry=%b", a8, b8, c8, s8c, co8c);
    end
    v8 = 1'b0;
  endtask

  task automatic test_reg_basic();
    logic [9:0] prev;
    @(negedge clk);
    prev = {s8r, co8r, ov8r};
    v8 = 1'b1; a8 = 8'h80; b8 = 8'h80; c8 = 1'b1;
    #4;
    tests_run++;
    if ({s8r, co8r, ov8r} !== prev) begin
      tests_failed++;
      $display("FAIL reg_early: got %h, want unchanged %h", {s8r, co8r, ov8r}, prev);
    end
    @(negedge clk);
    tests_run++;
    if (s8r !== 8'h01 || co8r !== 1'b1 || ov8r !== 1'b1) begin
      tests_failed++;
      $display("FAIL reg_basic: got sum=%h carry=%b ov=%b, want 01 1 1", s8r, co8r, ov8r);
    end
    $display("[TB] w8 reg 80+80+1 -> sum=%h carry=%b ov=%b", s8r, co8r, ov8r);
    v8 = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] av [3] = '{8'd1, 8'd3, 8'd0};
    logic [7:0] bv [3] = '{8'd2, 8'd4, 8'd0};
    logic       cv [3] = '{1'b0, 1'b1, 1'b0};
    logic       vv [3] = '{1'b1, 1'b1, 1'b0};
    exp_t       e;
    logic [7:0] hold_s;
    logic       hold_c;
    logic [8:0] r;
    q.delete();
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      if (q.size() > 0) begin
        e = q.pop_front();
        tests_run++;
        if (s8r !== e.s[7:0] || co8r !== e.c || ov8r !== e.v) begin
          tests_failed++;
          $display("FAIL back_to_back_%0d: got sum=%0d carry=%b ov=%b, want sum=%0d carry=%b ov=%b",
                   i, s8r, co8r, ov8r, e.s[7:0], e.c, e.v);
        end
        $display("[TB] b2b step %0d -> sum=%0d carry=%b ov=%b", i, s8r, co8r, ov8r);
      end
      if (i < 3) begin
        v8 = vv[i]; a8 = av[i]; b8 = bv[i]; c8 = cv[i];
        if (vv[i]) begin
          r = {1'b0, av[i]} + {1'b0, bv[i]} + {8'd0, cv[i]};
          hold_s = r[7:0];
          hold_c = r[8];
        end
        q.push_back('{v: vv[i], s: {8'd0, hold_s}, c: hold_c});
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset_midstream();
    @(negedge clk);
    v8 = 1'b1; a8 = 8'h7F; b8 = 8'h01; c8 = 1'b0;
    @(negedge clk);
    tests_run++;
    if (ov8r !== 1'b1 || s8r !== 8'h80) begin
      tests_failed++;
      $display("FAIL midreset_pre: got sum=%h ov=%b, want 80 1", s8r, ov8r);
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({s8r, co8r, ov8r} !== 10'd0) begin
      tests_failed++;
      $display("FAIL midreset_async: got sum=%h carry=%b ov=%b, want 0 0 0", s8r, co8r, ov8r);
    end
    $display("[TB] async reset mid-stream -> sum=%h ov=%b", s8r, ov8r);
    a8 = 8'hF0; b8 = 8'h0F; c8 = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({s8r, co8r, ov8r} !== 10'd0) begin
      tests_failed++;
      $display("FAIL midreset_held: got sum=%h carry=%b ov=%b, want 0 0 0", s8r, co8r, ov8r);
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (s8r !== 8'h00 || co8r !== 1'b1 || ov8r !== 1'b1) begin
      tests_failed++;
      $display("FAIL midreset_first: got sum=%h carry=%b ov=%b, want 00 1 1", s8r, co8r, ov8r);
    end
    $display("[TB] first result after reset -> sum=%h carry=%b ov=%b", s8r, co8r, ov8r);
    v8 = 1'b0;
  endtask

  task automatic test_random();
    exp_t        e;
    logic [16:0] r;
    logic [15:0] hold_s;
    logic        hold_c;
    logic        vin;
    int          errs_before;
    errs_before = tests_failed;
    q.delete();
    hold_s = '0;
    hold_c = 1'b0;
    @(negedge clk);
    for (int i = 0; i <= 10000; i++) begin
      if (q.size() > 0) begin
        e = q.pop_front();
        tests_run++;
        if (s16r !== e.s || co16r !== e.c || ov16r !== e.v) begin
          tests_failed++;
          $display("FAIL random_reg_%0d: got sum=%h carry=%b ov=%b, want sum=%h carry=%b ov=%b",
                   i, s16r, co16r, ov16r, e.s, e.c, e.v);
        end
      end
      if (i == 10000) break;
      vin = (i == 0) ? 1'b1 : ($urandom_range(0, 9) != 0);
      v16 = vin;
      a16 = 16'($urandom);
      b16 = 16'($urandom);
      c16 = 1'($urandom);
      if (i % 4 == 0) a16 = 16'hFFFF;
      r = add17(a16, b16, c16);
      if (vin) begin
        hold_s = r[15:0];
        hold_c = r[16];
      end
      q.push_back('{v: vin, s: hold_s, c: hold_c});
      #1;
      tests_run++;
      if ({co16c, s16c} !== r || ov16c !== vin) begin
        tests_failed++;
        $display("FAIL random_comb_%0d: got carry=%b sum=%h ov=%b, want carry=%b sum=%h ov=%b",
                 i, co16c, s16c, ov16c, r[16], r[15:0], vin);
      end
      @(negedge clk);
    end
    v16 = 1'b0;
    $display("[TB] random w16: 10000 vectors, %0d new failures", tests_failed - errs_before);
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    v1 = 1'b0; a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
    v8 = 1'b0; a8 = '0; b8 = '0; c8 = 1'b0;
    v16 = 1'b0; a16 = '0; b16 = '0; c16 = 1'b0;
    rst_n = 1'b0;
    test_reset();
    test_truth_table();
    test_comb8();
    test_reg_basic();
    test_back_to_back();
    test_reset_midstream();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
